// File: rtl/barcode_reader.sv
// Self-timed barcode receiver: measures the start-bit low time and reuses it as
// the sample delay for each of the 8 MSB-first data bits; captures a sticky ID.
module barcode_reader #(
  parameter int CNT_W   = 22,
  parameter int MIN_LOW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic       ID_vld,
  output logic [7:0] ID
);

  localparam int TW = CNT_W + 3;
  localparam logic [CNT_W-1:0] DUR_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_LOW   = 3'd1,
    WAIT_FALL   = 3'd2,
    WAIT_SAMPLE = 3'd3,
    CHECK       = 3'd4
  } state_t;

  // A station ID is valid only when its two upper bits are zero.
  function automatic logic id_ok(input logic [7:0] frame);
    return (frame[7:6] == 2'b00);
  endfunction

  logic [1:0]       sync_r;
  logic             prev_r;
  logic             bc_s, fall_s, rise_s;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] dur_r, dur_s, n_r, n_s;
  logic [TW-1:0]    timer_r, timer_s;
  logic [3:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       shift_r, shift_s, id_r, id_s;
  logic             id_vld_r, id_vld_s, set_s;

  assign bc_s   = sync_r[1];
  assign fall_s = prev_r & ~bc_s;
  assign rise_s = ~prev_r & bc_s;
  assign ID     = id_r;
  assign ID_vld = id_vld_r;

  // Two-flop synchronizer plus edge-detect history, all idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], BC};
      prev_r <= bc_s;
    end
  end

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    state_s   = state_r;
    dur_s     = dur_r;
    n_s       = n_r;
    timer_s   = timer_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    id_s      = id_r;
    set_s     = 1'b0;
    case (state_r)
      IDLE: begin
        dur_s   = '0;
        timer_s = '0;
        if (fall_s) begin
          state_s = START_LOW;
          dur_s   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_s = IDLE;
        end
      end
      START_LOW: begin
        if (rise_s) begin
          if (dur_r < MIN_LOW_C) begin
            state_s = IDLE;
            dur_s   = '0;
          end else begin
            n_s       = dur_r;
            bit_cnt_s = 4'd0;
            timer_s   = '0;
            state_s   = WAIT_FALL;
          end
        end else if (dur_r == DUR_MAX) begin
          state_s = IDLE;
          dur_s   = '0;
        end else if (!bc_s) begin
          dur_s = dur_r + 1'b1;
        end else begin
          dur_s = dur_r;
        end
      end
      WAIT_FALL: begin
        // Timeout at 8*N; timer is wide enough to reach that without wrapping.
        if (fall_s) begin
          timer_s = '0;
          state_s = WAIT_SAMPLE;
        end else if (timer_r == {n_r, 3'b000}) begin
          timer_s = '0;
          state_s = IDLE;
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      WAIT_SAMPLE: begin
        if (timer_r == {3'b000, n_r}) begin
          shift_s   = {shift_r[6:0], bc_s};
          bit_cnt_s = bit_cnt_r + 4'd1;
          timer_s   = '0;
          if (bit_cnt_r == 4'd7) begin
            state_s = CHECK;
          end else begin
            state_s = WAIT_FALL;
          end
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      CHECK: begin
        if (id_ok(shift_r)) begin
          id_s  = shift_r;
          set_s = 1'b1;
        end else begin
          id_s  = id_r;
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A capture in the same cycle as a clear leaves the flag set.
    if (set_s) begin
      id_vld_s = 1'b1;
    end else if (clr_ID_vld) begin
      id_vld_s = 1'b0;
    end else begin
      id_vld_s = id_vld_r;
    end
  end

  // Frame FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      dur_r     <= '0;
      n_r       <= '0;
      timer_r   <= '0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      id_r      <= 8'h00;
      id_vld_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      dur_r     <= dur_s;
      n_r       <= n_s;
      timer_r   <= timer_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      id_r      <= id_s;
      id_vld_r  <= id_vld_s;
    end
  end

endmodule
